// File: rtl/bcast_arb_pkg.sv
// Shared definitions for the broadcast-entry arbiter: sequencer state encoding
// and the width helper used for pointer, gap and drain counters.
package bcast_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Bits needed to index `value` items; never less than one bit.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    for (int i = 1; i < 31; i++) begin
      width = (int'(32'd1 << i) < value) ? (i + 1) : width;
    end
    return width;
  endfunction

endpackage

// File: rtl/bcast_arb_rr_pick.sv
// Combinational round-robin select: first set request at or above ptr_i,
// wrapping, returned both one-hot and as an index.
module rr_pick
  import bcast_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PW    = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PW-1:0]    ptr_i,
  output logic [N_REQ-1:0] sel_o,
  output logic [PW-1:0]    idx_o,
  output logic             valid_o
);

  logic [PW:0] pos_s;
  logic        hit_s;

  // Walk requesters starting at the pointer; the first hit wins.
  always_comb begin
    sel_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    pos_s   = '0;
    hit_s   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      pos_s = {1'b0, ptr_i} + (PW + 1)'(i);
      pos_s = (pos_s >= (PW + 1)'(N_REQ)) ? (pos_s - (PW + 1)'(N_REQ)) : pos_s;
      hit_s = ~valid_o & req_i[pos_s[PW-1:0]];
      sel_o[pos_s[PW-1:0]] = sel_o[pos_s[PW-1:0]] | hit_s;
      idx_o   = hit_s ? pos_s[PW-1:0] : idx_o;
      valid_o = valid_o | hit_s;
    end
  end

endmodule

// File: rtl/bcast_arb.sv
// Round-robin arbiter and packet sequencer in front of the broadcast network;
// streams one length-framed packet per grant and tracks network drain.
module bcast_arb
  import bcast_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int BCAST_WIDTH = 16,
  parameter int LEN_WIDTH   = 8,
  parameter int NET_DEPTH   = 4,
  parameter int GAP         = 1
) (
  input  logic                         CLK,
  input  logic                         reset,
  input  logic [N_REQ-1:0]             req,
  input  logic [N_REQ*LEN_WIDTH-1:0]   req_len,
  input  logic [N_REQ*BCAST_WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]             req_valid,
  output logic [N_REQ-1:0]             req_rd,
  output logic [N_REQ-1:0]             grant,
  output logic                         bcast_en,
  output logic [BCAST_WIDTH-1:0]       bcast_out,
  output logic                         pkt_start,
  output logic                         pkt_end,
  output logic                         idle
);

  localparam int PW = clog2(N_REQ);
  localparam int GW = clog2(GAP + 1);
  localparam int DW = clog2(NET_DEPTH + 1);
  localparam logic [GW-1:0] GAP_LAST  = (GAP > 0) ? GW'(GAP - 1) : '0;
  localparam logic [DW-1:0] DRAIN_MAX = DW'(NET_DEPTH);
  localparam logic [PW-1:0] PTR_MAX   = PW'(N_REQ - 1);

  function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] idx);
    return (idx == PTR_MAX) ? '0 : (idx + PW'(1));
  endfunction

  state_e                 state_q, state_d;
  logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]          sel_q, sel_d;
  logic [N_REQ-1:0]       grant_q, grant_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [LEN_WIDTH-1:0]   word_q, word_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic [DW-1:0]          drain_q, drain_d;
  logic                   bcast_en_q, bcast_en_d;
  logic [BCAST_WIDTH-1:0] bcast_out_q, bcast_out_d;
  logic                   pkt_start_q, pkt_start_d;
  logic                   pkt_end_q, pkt_end_d;
  logic                   idle_q, idle_d;

  logic [N_REQ-1:0]       pick_sel_s;
  logic [PW-1:0]          pick_idx_s;
  logic                   pick_valid_s;
  logic [LEN_WIDTH-1:0]   pick_len_s;
  logic [BCAST_WIDTH-1:0] sel_data_s;
  logic                   accept_s;
  logic                   last_s;

  rr_pick #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_rr_pick (
    .req_i   (req),
    .ptr_i   (rr_ptr_q),
    .sel_o   (pick_sel_s),
    .idx_o   (pick_idx_s),
    .valid_o (pick_valid_s)
  );

  assign pick_len_s = req_len[int'(pick_idx_s)*LEN_WIDTH +: LEN_WIDTH];
  assign sel_data_s = req_data[int'(sel_q)*BCAST_WIDTH +: BCAST_WIDTH];
  assign accept_s   = (state_q == ST_SEND) & req_valid[sel_q];
  assign last_s     = accept_s & (word_q == (len_q - LEN_WIDTH'(1)));
  assign req_rd     = (state_q == ST_SEND) ? (grant_q & req_valid) : '0;

  // Sequencer next state and registered-output staging.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    sel_d       = sel_q;
    grant_d     = grant_q;
    len_d       = len_q;
    word_d      = word_q;
    gap_d       = gap_q;
    bcast_en_d  = 1'b0;
    bcast_out_d = bcast_out_q;
    pkt_start_d = 1'b0;
    pkt_end_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        grant_d = pick_sel_s;
        word_d  = '0;
        if (pick_valid_s) begin
          sel_d = pick_idx_s;
          len_d = pick_len_s;
          // An empty packet consumes its turn without touching the network.
          if (pick_len_s == '0) begin
            rr_ptr_d = ptr_after(pick_idx_s);
            state_d  = ST_IDLE;
          end else begin
            state_d = ST_SEND;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        bcast_en_d  = accept_s;
        bcast_out_d = accept_s ? sel_data_s : bcast_out_q;
        pkt_start_d = accept_s & (word_q == '0);
        pkt_end_d   = last_s;
        word_d      = accept_s ? (word_q + LEN_WIDTH'(1)) : word_q;
        if (last_s) begin
          rr_ptr_d = ptr_after(sel_q);
          grant_d  = '0;
          gap_d    = '0;
          state_d  = (GAP == 0) ? ST_IDLE : ST_GAP;
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = ST_IDLE;
        end else begin
          gap_d   = gap_q + GW'(1);
          state_d = ST_GAP;
        end
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Drain counter saturates once the last word has cleared every hop.
  always_comb begin
    drain_d = bcast_en_q ? '0 : ((drain_q == DRAIN_MAX) ? drain_q : (drain_q + DW'(1)));
    idle_d  = (state_q == ST_IDLE) & (drain_q == DRAIN_MAX) & ~(|req);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      sel_q       <= '0;
      grant_q     <= '0;
      len_q       <= '0;
      word_q      <= '0;
      gap_q       <= '0;
      drain_q     <= '0;
      bcast_en_q  <= 1'b0;
      bcast_out_q <= '0;
      pkt_start_q <= 1'b0;
      pkt_end_q   <= 1'b0;
      idle_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      sel_q       <= sel_d;
      grant_q     <= grant_d;
      len_q       <= len_d;
      word_q      <= word_d;
      gap_q       <= gap_d;
      drain_q     <= drain_d;
      bcast_en_q  <= bcast_en_d;
      bcast_out_q <= bcast_out_d;
      pkt_start_q <= pkt_start_d;
      pkt_end_q   <= pkt_end_d;
      idle_q      <= idle_d;
    end
  end

  assign grant     = grant_q;
  assign bcast_en  = bcast_en_q;
  assign bcast_out = bcast_out_q;
  assign pkt_start = pkt_start_q;
  assign pkt_end   = pkt_end_q;
  assign idle      = idle_q;

endmodule

// File: tb/tb_bcast_arb.sv
// Self-checking bench for bcast_arb: transaction-level reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_bcast_arb;

  localparam int N  = 4;
  localparam int BW = 16;
  localparam int LW = 8;
  localparam int ND = 4;
  localparam int GP = 1;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*LW-1:0] req_len;
  logic [N*BW-1:0] req_data;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_rd;
  logic [N-1:0]    grant;
  logic            bcast_en;
  logic [BW-1:0]   bcast_out;
  logic            pkt_start;
  logic            pkt_end;
  logic            idle;

  bcast_arb #(
    .N_REQ(N), .BCAST_WIDTH(BW), .LEN_WIDTH(LW), .NET_DEPTH(ND), .GAP(GP)
  ) dut (
    .CLK(clk), .reset(reset), .req(req), .req_len(req_len), .req_data(req_data),
    .req_valid(req_valid), .req_rd(req_rd), .grant(grant), .bcast_en(bcast_en),
    .bcast_out(bcast_out), .pkt_start(pkt_start), .pkt_end(pkt_end), .idle(idle)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cnt [N];

  // Reference model: who owns the entry, words left, gap left, quiet time.
  int            m_ptr, m_owner, m_left, m_sent, m_gap, m_quiet;
  logic [N-1:0]  e_grant;
  logic          e_en, e_start, e_end, e_idle;
  logic [BW-1:0] e_out;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int ptr);
    for (int j = 0; j < N; j++) begin
      if (r[(ptr + j) % N]) return (ptr + j) % N;
    end
    return -1;
  endfunction

  function automatic int oh_idx(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return -1;
  endfunction

  task automatic m_reset();
    m_ptr = 0; m_owner = -1; m_left = 0; m_sent = 0; m_gap = 0; m_quiet = 0;
    e_grant = '0; e_en = 1'b0; e_start = 1'b0; e_end = 1'b0; e_idle = 1'b0; e_out = '0;
  endtask

  function automatic logic [N-1:0] exp_rd();
    logic [N-1:0] r;
    r = '0;
    if (m_owner >= 0 && req_valid[m_owner]) r[m_owner] = 1'b1;
    return r;
  endfunction

  // What the outputs must be after the coming clock edge, given current inputs.
  task automatic predict();
    int s, len;
    logic idle_now;
    if (reset) begin
      m_reset();
      return;
    end
    idle_now = (m_owner < 0) && (m_gap == 0);
    e_idle   = idle_now && (m_quiet == ND) && (req == '0);
    m_quiet  = e_en ? 0 : ((m_quiet < ND) ? m_quiet + 1 : ND);
    e_en = 1'b0; e_start = 1'b0; e_end = 1'b0;
    if (idle_now) begin
      s = pick(req, m_ptr);
      e_grant = '0;
      if (s >= 0) begin
        e_grant[s] = 1'b1;
        len = int'(req_len[s*LW +: LW]);
        if (len == 0) m_ptr = (s + 1) % N;
        else begin m_owner = s; m_left = len; m_sent = 0; end
      end
    end else if (m_owner >= 0) begin
      if (req_valid[m_owner]) begin
        e_en    = 1'b1;
        e_out   = req_data[m_owner*BW +: BW];
        e_start = (m_sent == 0);
        e_end   = (m_left == 1);
        m_sent++;
        m_left--;
        if (m_left == 0) begin
          m_ptr = (m_owner + 1) % N; m_owner = -1; e_grant = '0; m_gap = GP;
        end
      end
    end else begin
      m_gap--;
    end
  endtask

  // Compare process: registered outputs at negedge, req_rd after inputs settle.
  initial begin
    m_reset();
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("grant", 64'(grant), 64'(e_grant));
      chk("bcast_en", 64'(bcast_en), 64'(e_en));
      chk("bcast_out", 64'(bcast_out), 64'(e_out));
      chk("pkt_start", 64'(pkt_start), 64'(e_start));
      chk("pkt_end", 64'(pkt_end), 64'(e_end));
      chk("idle", 64'(idle), 64'(e_idle));
      #2;
      chk("req_rd", 64'(req_rd), 64'(exp_rd()));
      predict();
    end
  end

  task automatic drive_data();
    for (int i = 0; i < N; i++) req_data[i*BW +: BW] = 16'h00A0 + 16'(i) * 16'h0100 + 16'(cnt[i]);
  endtask

  task automatic set_len(input int i, input int len);
    req_len[i*LW +: LW] = LW'(len);
  endtask

  // One clock: note words taken by the DUT, then return just after the negedge.
  task automatic tick();
    logic [N-1:0] rd;
    #2;
    rd = req_rd;
    for (int i = 0; i < N; i++) if (rd[i]) cnt[i]++;
    @(negedge clk);
    #1;
    drive_data();
  endtask

  task automatic settle(input int n);
    req = '0;
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    int gorder[$];
    int entimes[$];
    int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
    int en_total;
    logic [N-1:0] prev_g;

    reset = 1'b1; req = '0; req_valid = '0; req_len = '0;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    drive_data();
    tick(); tick();

    // Reset release with no requests: idle rises on the fifth cycle.
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("t1_idle", 64'(idle), (k == 5) ? 64'd1 : 64'd0);
      chk("t1_en", 64'(bcast_en), 64'd0);
    end

    // Single 3-word packet from requester 0.
    for (int i = 0; i < N; i++) cnt[i] = 0;
    drive_data();
    set_len(0, 3); req = 4'b0001; req_valid = 4'b1111;
    tick();
    req = '0;
    chk("t2_grant", 64'(grant), 64'd1);
    chk("t2_en0", 64'(bcast_en), 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t2_en", 64'(bcast_en), 64'd1);
      chk("t2_out", 64'(bcast_out), 64'h00A0 + 64'(k));
      chk("t2_start", 64'(pkt_start), (k == 0) ? 64'd1 : 64'd0);
      chk("t2_end", 64'(pkt_end), (k == 2) ? 64'd1 : 64'd0);
      if (k < 2) chk("t2_grant_hold", 64'(grant), 64'd1);
    end
    tick();
    chk("t2_en_after", 64'(bcast_en), 64'd0);
    settle(6);

    // Fairness after reset: all requesting, one-word packets.
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    for (int i = 0; i < N; i++) set_len(i, 1);
    req = 4'b1111; req_valid = 4'b1111; prev_g = '0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (grant != '0 && prev_g == '0) gorder.push_back(oh_idx(grant));
      if (bcast_en) entimes.push_back(k);
      prev_g = grant;
    end
    chk("t3_ngrants", 64'(gorder.size() >= 5), 64'd1);
    for (int k = 0; k < 5; k++) if (k < gorder.size()) chk("t3_order", 64'(gorder[k]), 64'(k % 4));
    for (int k = 1; k < 5; k++) if (k < entimes.size()) chk("t3_spacing", 64'(entimes[k] - entimes[k-1]), 64'd3);
    settle(8);

    // Stalling source: 4 words delivered under a gappy valid pattern.
    req_valid = '0; set_len(2, 4); req = 4'b0100;
    tick();
    req = '0;
    chk("t4_grant", 64'(grant), 64'd4);
    en_total = 0;
    for (int j = 0; j < 7; j++) begin
      req_valid[2] = pat[j][0];
      tick();
      chk("t4_en", 64'(bcast_en), 64'(pat[j]));
      en_total += int'(bcast_en);
    end
    req_valid = '0;
    for (int k = 0; k < 3; k++) begin tick(); en_total += int'(bcast_en); end
    chk("t4_total", 64'(en_total), 64'd4);
    settle(6);

    // Zero-length packet: one-cycle grant, pointer still advances.
    req_valid = 4'b1111; set_len(1, 0); req = 4'b0010;
    tick();
    chk("t5_grant", 64'(grant), 64'd2);
    chk("t5_en", 64'(bcast_en), 64'd0);
    req = '0;
    tick();
    chk("t5_grant_drop", 64'(grant), 64'd0);
    set_len(1, 2); set_len(2, 2); req = 4'b0110;
    tick();
    chk("t5_next", 64'(grant), 64'd4);
    settle(10);

    // Reset mid-packet, then priority restarts at requester 0.
    set_len(1, 5); req = 4'b0010;
    tick();
    req = '0;
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("t6_en", 64'(bcast_en), 64'd0);
    chk("t6_grant", 64'(grant), 64'd0);
    chk("t6_end", 64'(pkt_end), 64'd0);
    chk("t6_out", 64'(bcast_out), 64'd0);
    reset = 1'b0; set_len(1, 1); set_len(3, 1); req = 4'b1010;
    tick();
    chk("t6_prio", 64'(grant), 64'd2);
    settle(8);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) req = N'($urandom);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) set_len(i, ($urandom_range(0, 9) == 0) ? 9 : $urandom_range(0, 5));
        req_valid[i] = ($urandom_range(0, 3) != 0);
      end
      tick();
    end
    reset = 1'b0;
    settle(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
